// File: rtl/uart_tx_ctrl_module.sv
// UART TX frame controller: start bit, DATA_BITS LSB-first, STOP_BITS stop bits; one bit per BPS_CLK tick, 1-cycle accept latency.
// Define TX_PARITY_EN to insert an even-parity slot after the MSB. All outputs registered; TX_En is only sampled in IDLE.
module uart_tx_ctrl_module #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 CLK,
    input  logic                 Rstn,
    input  logic                 TX_En,
    input  logic [DATA_BITS-1:0] TX_Data,
    input  logic                 BPS_CLK,
    output logic                 Count_Sig,
    output logic                 TX_Pin_Out,
    output logic                 TX_Busy,
    output logic                 TX_Done
);

`ifdef TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int CNT_W = $clog2(DATA_BITS + STOP_BITS + 4);
    localparam logic [CNT_W-1:0] START_K     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_DATA_K = CNT_W'(DATA_BITS + 1);
`ifdef TX_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_K       = CNT_W'(DATA_BITS + 2);
`endif
    // The tick after the last stop bit closes the frame.
    localparam logic [CNT_W-1:0] LAST_K      = CNT_W'(DATA_BITS + PAR_BITS + STOP_BITS + 2);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pin_q, pin_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_W'(1);
        shift_d = shift_q;
        pin_d   = pin_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                pin_d = 1'b1;
                if (TX_En) begin
                    state_d = SEND;
                    shift_d = TX_Data;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
`ifdef TX_PARITY_EN
                    par_d   = ^TX_Data;
`endif
                end
            end
            SEND: begin
                if (BPS_CLK) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == START_K) begin
                        pin_d = 1'b0;
                    end else if (cnt_inc <= LAST_DATA_K) begin
                        pin_d   = shift_q[0];
                        shift_d = shift_q >> 1;
`ifdef TX_PARITY_EN
                    end else if (cnt_inc == PAR_K) begin
                        pin_d = par_q;
`endif
                    end else begin
                        pin_d = 1'b1;
                    end
                    if (cnt_inc == LAST_K) begin
                        state_d = DONE;
                        cs_d    = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign Count_Sig  = cs_q;
    assign TX_Pin_Out = pin_q;
    assign TX_Busy    = busy_q;
    assign TX_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl_module.sv
// Scoreboard bench for uart_tx_ctrl_module: expected line bits are queued when a byte is offered and popped on each baud tick.
// The bench also plays the baud generator (one BPS_CLK pulse every 16 CLK while Count_Sig=1).
module tb_uart_tx_ctrl_module;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
`ifdef TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_TICKS = DATA_BITS + PAR_BITS + STOP_BITS + 2;

    typedef struct packed {
        logic bit_v;
        logic last;
    } exp_t;

    logic                 CLK = 1'b0;
    logic                 Rstn = 1'b0;
    logic                 TX_En = 1'b0;
    logic [DATA_BITS-1:0] TX_Data = '0;
    logic                 BPS_CLK = 1'b0;
    logic                 Count_Sig;
    logic                 TX_Pin_Out;
    logic                 TX_Busy;
    logic                 TX_Done;

    int   checks = 0;
    int   failures = 0;
    int   ticks_seen = 0;
    int   done_cnt = 0;
    logic idle_pulse = 1'b0;
    exp_t exp_q[$];

    uart_tx_ctrl_module #(.DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS)) dut (
        .CLK       (CLK),
        .Rstn      (Rstn),
        .TX_En     (TX_En),
        .TX_Data   (TX_Data),
        .BPS_CLK   (BPS_CLK),
        .Count_Sig (Count_Sig),
        .TX_Pin_Out(TX_Pin_Out),
        .TX_Busy   (TX_Busy),
        .TX_Done   (TX_Done)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic push_frame(input logic [DATA_BITS-1:0] d);
        exp_t e;
        e.last  = 1'b0;
        e.bit_v = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < DATA_BITS; i++) begin
            e.bit_v = d[i];
            exp_q.push_back(e);
        end
`ifdef TX_PARITY_EN
        e.bit_v = ^d;
        exp_q.push_back(e);
`endif
        for (int i = 0; i < STOP_BITS; i++) begin
            e.bit_v = 1'b1;
            exp_q.push_back(e);
        end
        e.bit_v = 1'b1;
        e.last  = 1'b1;
        exp_q.push_back(e);
    endtask

    // Offer a byte while the DUT is idle and check the accept cycle.
    task automatic start_frame(input logic [DATA_BITS-1:0] d);
        TX_Data = d;
        TX_En   = 1'b1;
        push_frame(d);
        cyc();
        chk("accept_cs", Count_Sig, 1);
        chk("accept_busy", TX_Busy, 1);
        chk("accept_line", TX_Pin_Out, 1);
    endtask

    task automatic wait_done(input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 600) begin
            cyc();
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt - start, 1);
    endtask

    // Monitor plus baud generator: sample just after each posedge's effect, then set BPS_CLK for the next edge.
    initial begin : monitor
        logic cs_last;
        logic tick;
        logic exp_done;
        int   div;
        exp_t e;
        cs_last = 1'b0;
        div = 0;
        forever begin
            @(negedge CLK);
            tick = BPS_CLK && cs_last && Rstn;
            exp_done = 1'b0;
            if (tick) begin
                ticks_seen++;
                chk("exp_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tx_bit", TX_Pin_Out, e.bit_v);
                    chk("cs_at_tick", Count_Sig, !e.last);
                    exp_done = e.last;
                end
            end
            chk("done_pulse", TX_Done, exp_done);
            if (Count_Sig) chk("busy_in_frame", TX_Busy, 1);
            if (TX_Done) begin
                done_cnt++;
                chk("busy_at_done", TX_Busy, 1);
            end
            cs_last = Count_Sig;
            if (Count_Sig) begin
                if (div == 15) begin
                    BPS_CLK = 1'b1;
                    div = 0;
                end else begin
                    BPS_CLK = 1'b0;
                    div++;
                end
            end else begin
                div = 0;
                BPS_CLK = idle_pulse;
            end
        end
    end

    initial begin : stimulus
        int t0;
        int d0;
        int gap;
        int n;

        Rstn = 1'b0;
        repeat (3) cyc();
        chk("rst_line", TX_Pin_Out, 1);
        chk("rst_cs", Count_Sig, 0);
        chk("rst_busy", TX_Busy, 0);
        chk("rst_done", TX_Done, 0);
        Rstn = 1'b1;
        cyc();
        chk("idle_line", TX_Pin_Out, 1);
        chk("idle_cs", Count_Sig, 0);

        // Baud pulses in IDLE must do nothing; the last one coincides with the accept edge.
        idle_pulse = 1'b1;
        repeat (4) cyc();
        chk("idle_pulse_line", TX_Pin_Out, 1);
        chk("idle_pulse_cs", Count_Sig, 0);
        chk("idle_pulse_busy", TX_Busy, 0);

        t0 = ticks_seen;
        d0 = done_cnt;
        start_frame(8'hA5);
        idle_pulse = 1'b0;
        TX_En = 1'b0;
        wait_done("a5");
        chk("a5_ticks", ticks_seen - t0, FRAME_TICKS);
        chk("a5_cs_at_done", Count_Sig, 0);
        cyc();
        chk("a5_done_width", TX_Done, 0);
        chk("a5_busy_after", TX_Busy, 0);
        chk("a5_done_count", done_cnt - d0, 1);

        // Back-to-back with TX_En held high; data changes while frames are in flight.
        t0 = ticks_seen;
        start_frame(8'h00);
        TX_Data = 8'hFF;
        push_frame(8'hFF);
        wait_done("b2b0");
        chk("b2b0_ticks", ticks_seen - t0, FRAME_TICKS);
        gap = 0;
        while (Count_Sig == 1'b0 && gap < 10) begin
            cyc();
            gap++;
        end
        chk("b2b_gap", gap, 2);
        t0 = ticks_seen;
        TX_Data = 8'h5A;
        repeat (20) cyc();
        TX_En = 1'b0;
        wait_done("b2b1");
        chk("b2b1_ticks", ticks_seen - t0, FRAME_TICKS);
        cyc();

        // Reset in the middle of a frame, right after data bit 3 of 8'h3C.
        t0 = ticks_seen;
        d0 = done_cnt;
        start_frame(8'h3C);
        TX_En = 1'b0;
        n = 0;
        while (ticks_seen - t0 < 5 && n < 200) begin
            cyc();
            n++;
        end
        chk("mid_reached_bit3", ticks_seen - t0, 5);
        Rstn = 1'b0;
        cyc();
        chk("mid_rst_line", TX_Pin_Out, 1);
        chk("mid_rst_cs", Count_Sig, 0);
        chk("mid_rst_busy", TX_Busy, 0);
        chk("mid_rst_done", TX_Done, 0);
        exp_q.delete();
        Rstn = 1'b1;
        repeat (40) cyc();
        chk("mid_no_done", done_cnt - d0, 0);
        t0 = ticks_seen;
        start_frame(8'h55);
        TX_En = 1'b0;
        wait_done("post_rst");
        chk("post_rst_ticks", ticks_seen - t0, FRAME_TICKS);
        cyc();

        // TX_En pulses during SEND and during DONE are ignored.
        t0 = ticks_seen;
        d0 = done_cnt;
        start_frame(8'h81);
        TX_En = 1'b0;
        repeat (50) cyc();
        TX_Data = 8'hFF;
        TX_En = 1'b1;
        cyc();
        TX_En = 1'b0;
        wait_done("en_pulse");
        TX_En = 1'b1;
        cyc();
        TX_En = 1'b0;
        repeat (40) cyc();
        chk("en_pulse_one_done", done_cnt - d0, 1);
        chk("en_pulse_ticks", ticks_seen - t0, FRAME_TICKS);
        chk("en_pulse_idle_cs", Count_Sig, 0);
        chk("en_pulse_idle_busy", TX_Busy, 0);

        // Parity-sensitive bytes: odd and even population counts.
        t0 = ticks_seen;
        start_frame(8'h07);
        TX_En = 1'b0;
        wait_done("b07");
        chk("b07_ticks", ticks_seen - t0, FRAME_TICKS);
        cyc();
        t0 = ticks_seen;
        start_frame(8'h03);
        TX_En = 1'b0;
        wait_done("b03");
        chk("b03_ticks", ticks_seen - t0, FRAME_TICKS);
        cyc();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_ctrl_module.md
Name: uart_tx_ctrl_module

Overview:
UART transmit frame controller: the consumer of the baud-tick generator in the UART TX path.
- Accepts one byte per request.
- Drives Count_Sig to start and stop the baud counter.
- Advances one bit per BPS_CLK pulse and shifts out an 8N1 frame (optionally 8E1) on the serial line.
- Sits between the user or data source and the pin; reports completion with a one-cycle done pulse.

Parameters:
DATA_BITS, 8, number of data bits per frame, sent LSB first.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
CLK  input  1  system clock (50 MHz)
Rstn  input  1  synchronous active-low reset, sampled on rising CLK
TX_En  input  1  transmit request; sampled only in IDLE
TX_Data  input  DATA_BITS  byte to send; captured on the accept cycle
BPS_CLK  input  1  one-cycle baud tick from the baud generator; valid only while Count_Sig=1
Count_Sig  output  1  enables the baud counter; high for the whole frame
TX_Pin_Out  output  1  serial line, idle high
TX_Busy  output  1  high from accept until the cycle TX_Done is asserted (inclusive)
TX_Done  output  1  one-cycle pulse at end of frame

Behaviour:
- One clock (CLK). Reset is synchronous and active-low (Rstn); all registers update only on rising CLK.
- Reset values: TX_Pin_Out=1, Count_Sig=0, TX_Busy=0, TX_Done=0, state=IDLE, bit counter=0, shift register=0.
- Reset mid-frame: on the first edge with Rstn=0, all outputs return to reset values (line high), regardless of state.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, SEND, DONE.
- IDLE:
  - TX_Pin_Out=1; BPS_CLK is ignored.
  - On TX_En=1: latch TX_Data into the shift register, clear the tick counter, set Count_Sig=1 and TX_Busy=1, go to SEND.
  - Accept latency: 1 cycle.
- SEND: each BPS_CLK pulse increments the tick counter k and drives, on the next edge:
  - k=1: start bit, 0.
  - k=2..DATA_BITS+1: data bit k-2, LSB first.
  - Parity slot (only when TX_PARITY_EN is defined): next tick after the data bits.
  - Following STOP_BITS ticks: line = 1.
  - One further tick after the last stop bit ends the frame: line held 1, go to DONE.
  - Cycles without BPS_CLK: hold all outputs.
  - Line before the first tick: stays 1 after accept (no glitch).
- DONE (exactly 1 cycle):
  - TX_Done=1, Count_Sig=0, TX_Busy=0 on exit.
  - Go to IDLE.
  - TX_En during DONE is ignored; it is accepted on the next cycle if still high.
- Frame length (8N1): 11 BPS_CLK ticks from accept to DONE; 12 with parity; +1 per extra stop bit.
- TX_En held high continuously:
  - Frames are back-to-back.
  - Idle gap is 2 CLK cycles: DONE, then the IDLE accept cycle.
- TX_En or TX_Data changes during SEND have no effect; the latched byte is used.
- A BPS_CLK pulse coinciding with the accept cycle is ignored, because the counter starts in SEND.
- Tick counter width: ceil(log2(DATA_BITS+STOP_BITS+4)). It never wraps inside a frame and is cleared on accept.

Optional Feature:
TX_PARITY_EN
- Defined:
  - One even-parity bit (XOR of the latched data bits) is inserted after the MSB and before the stop bits.
  - Frame becomes 8E1; tick count +1.
- Undefined:
  - No parity slot; frame is 8N1.
  - The parity logic is not present in the netlist.

Test Plan:
Bench setup for all scenarios: BPS_CLK is a one-cycle pulse every 16 CLK while Count_Sig=1.
- Reset then idle: hold Rstn=0 for 3 cycles, then release -> TX_Pin_Out=1, Count_Sig=0, TX_Busy=0, TX_Done=0; BPS_CLK pulses in IDLE cause no change.
- Single byte 8'hA5 (TX_En 1 cycle):
  - Line sequence per tick: 0,1,0,1,0,0,1,0,1,1.
  - TX_Done pulses once, 1 cycle, after the 11th tick.
  - Count_Sig falls in the same cycle; TX_Busy is high throughout the frame.
- Back-to-back with TX_En held high, bytes 8'h00 then 8'hFF:
  - Second frame starts 2 cycles after TX_Done.
  - Second frame is 0,1×8,1.
  - Data changed mid-frame does not affect the bits sent.
- Reset mid-frame: assert Rstn=0 at data bit 3 of 8'h3C -> next edge TX_Pin_Out=1, Count_Sig=0, TX_Busy=0; no TX_Done. A new 8'h55 after release transmits correctly.
- TX_En pulsed during SEND and during DONE -> ignored; exactly one frame and one TX_Done.
- With TX_PARITY_EN, byte 8'h07 -> parity bit 1 after MSB; with 8'h03 -> parity bit 0; TX_Done after 12 ticks.
